// File: rtl/aes_pipe_sequencer.sv
// aes_pipe_sequencer: turns a controller start level into single issues to a
// pipelined AES core, queues results in a credit-limited FIFO, paces delivery.
module aes_pipe_sequencer #(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 4,
   parameter int GAP     = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         decrypt_i,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic         core_valid_o,
   output logic         core_decrypt_o,
   output logic [127:0] core_data_o,
   output logic [127:0] core_key_o,
   input  logic         core_valid_i,
   input  logic [127:0] core_data_i,
   output logic         ready_o,
   output logic [127:0] data_o,
   output logic         busy_o,
   output logic         overflow_o,
   output logic         unexpected_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   if (DEPTH < 1 || GAP < 0 || LATENCY < 1) begin : g_param_check
      $error("aes_pipe_sequencer: illegal parameter set");
   end

   logic          load_q;
   logic          pending;
   logic          slot_dec;
   logic [127:0]  slot_data;
   logic [127:0]  slot_key;
   logic          last_dec;
   logic [127:0]  last_data;
   logic [127:0]  last_key;
   logic [CW-1:0] inflight;
   logic [127:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [0:0]    state;
   logic [GW-1:0] gap_cnt;
   logic [127:0]  data_q;
   logic          overflow_q;
   logic          unexpected_q;

   logic start;
   logic issue;
   logic accept;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign start  = load_i & ~load_q;
   assign issue  = pending & (inflight < DEPTH_C);
   assign accept = start & (~pending | issue);
   assign push   = core_valid_i & (inflight != '0);
   assign pop    = (state == IDLE) & (count != '0);

   assign core_valid_o   = issue;
   assign core_decrypt_o = issue ? slot_dec  : last_dec;
   assign core_data_o    = issue ? slot_data : last_data;
   assign core_key_o     = issue ? slot_key  : last_key;

   assign ready_o      = pop;
   assign data_o       = pop ? mem[rd_ptr] : data_q;
   assign busy_o       = pending | (inflight != '0);
   assign overflow_o   = overflow_q;
   assign unexpected_o = unexpected_q;

   // Edge-detect the start level and hold one request in the pending slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_q     <= 1'b0;
         pending    <= 1'b0;
         slot_dec   <= 1'b0;
         slot_data  <= '0;
         slot_key   <= '0;
         overflow_q <= 1'b0;
      end else begin
         load_q <= load_i;
         if (accept) begin
            pending   <= 1'b1;
            slot_dec  <= decrypt_i;
            slot_data <= data_i;
            slot_key  <= key_i;
         end else if (issue) begin
            pending <= 1'b0;
         end
         if (start & ~accept) overflow_q <= 1'b1;
      end
   end

   // Remember the last issued request so core_* hold between issues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_dec  <= 1'b0;
         last_data <= '0;
         last_key  <= '0;
      end else if (issue) begin
         last_dec  <= slot_dec;
         last_data <= slot_data;
         last_key  <= slot_key;
      end
   end

   // Credit counter: issued requests whose result has not been delivered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight     <= '0;
         unexpected_q <= 1'b0;
      end else begin
         unique case ({issue, pop})
            2'b10:   inflight <= inflight + ONE_C;
            2'b01:   inflight <= inflight - ONE_C;
            default: ;
         endcase
         if (core_valid_i & (inflight == '0)) unexpected_q <= 1'b1;
      end
   end

   // Result storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= core_data_i;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + ONE_C;
            2'b01:   count <= count - ONE_C;
            default: ;
         endcase
      end
   end

   // Drain FSM: deliver one result, then stay quiet for GAP cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         gap_cnt <= '0;
         data_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  data_q  <= mem[rd_ptr];
                  gap_cnt <= '0;
                  state   <= (GAP == 0) ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_pipe_sequencer.sv
// tb_aes_pipe_sequencer: directed and randomized checks of the sequencer
// against a queue-based core model and result scoreboard.
module tb_aes_pipe_sequencer;

   localparam int LATENCY = 10;
   localparam int DEPTH   = 4;
   localparam int GAP     = 3;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_i;
   logic         decrypt_i;
   logic [127:0] data_i;
   logic [127:0] key_i;
   logic         core_valid_o;
   logic         core_decrypt_o;
   logic [127:0] core_data_o;
   logic [127:0] core_key_o;
   logic         core_valid_i;
   logic [127:0] core_data_i;
   logic         ready_o;
   logic [127:0] data_o;
   logic         busy_o;
   logic         overflow_o;
   logic         unexpected_o;

   aes_pipe_sequencer #(
      .LATENCY(LATENCY),
      .DEPTH(DEPTH),
      .GAP(GAP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .load_i(load_i),
      .decrypt_i(decrypt_i),
      .data_i(data_i),
      .key_i(key_i),
      .core_valid_o(core_valid_o),
      .core_decrypt_o(core_decrypt_o),
      .core_data_o(core_data_o),
      .core_key_o(core_key_o),
      .core_valid_i(core_valid_i),
      .core_data_i(core_data_i),
      .ready_o(ready_o),
      .data_o(data_o),
      .busy_o(busy_o),
      .overflow_o(overflow_o),
      .unexpected_o(unexpected_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [127:0] d;
      logic [127:0] k;
      logic         dec;
      bit           stale;
   } req_t;

   typedef struct {
      int           cyc;
      logic [127:0] d;
      logic [127:0] k;
      logic         dec;
   } iss_t;

   req_t         core_q[$];
   iss_t         iss_q[$];
   logic [127:0] exp_q[$];
   int           rdy_cyc[$];
   logic [127:0] rdy_dat[$];

   int cyc   = 0;
   int total = 0;
   int bad   = 0;
   bit stall = 1'b0;
   bit spur  = 1'b0;

   // Stand-in for the AES core: the known vector maps to its ciphertext,
   // anything else to an arbitrary but deterministic scramble.
   function automatic logic [127:0] core_fn(input logic [127:0] d,
                                            input logic [127:0] k,
                                            input logic dec);
      if (d == PT && k == KEY && !dec) return CT;
      return d ^ {k[63:0], k[127:64]} ^ {128{dec}};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk128(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string p);
      chk1({p, "_core_valid"}, core_valid_o, 1'b0);
      chk1({p, "_core_dec"}, core_decrypt_o, 1'b0);
      chk128({p, "_core_data"}, core_data_o, '0);
      chk128({p, "_core_key"}, core_key_o, '0);
      chk1({p, "_ready"}, ready_o, 1'b0);
      chk128({p, "_data_o"}, data_o, '0);
      chk1({p, "_busy"}, busy_o, 1'b0);
      chk1({p, "_overflow"}, overflow_o, 1'b0);
      chk1({p, "_unexpected"}, unexpected_o, 1'b0);
   endtask

   // One clock: observe the DUT mid-cycle, then drive the core model.
   task automatic tick();
      req_t r;
      iss_t s;
      @(posedge clk);
      #1;
      cyc++;
      if (core_valid_o) begin
         s.cyc = cyc;
         s.d   = core_data_o;
         s.k   = core_key_o;
         s.dec = core_decrypt_o;
         iss_q.push_back(s);
         r.due   = cyc + LATENCY;
         r.d     = core_data_o;
         r.k     = core_key_o;
         r.dec   = core_decrypt_o;
         r.stale = 1'b0;
         core_q.push_back(r);
      end
      if (ready_o) begin
         rdy_cyc.push_back(cyc);
         rdy_dat.push_back(data_o);
         if (exp_q.size() == 0) chk1("ready_spurious", ready_o, 1'b0);
         else chk128("ready_data", data_o, exp_q.pop_front());
      end
      core_valid_i = 1'b0;
      core_data_i  = '0;
      if (spur) begin
         core_valid_i = 1'b1;
         core_data_i  = rnd128();
         spur         = 1'b0;
      end else if (!stall && core_q.size() > 0 && core_q[0].due <= cyc) begin
         r = core_q.pop_front();
         core_valid_i = 1'b1;
         core_data_i  = core_fn(r.d, r.k, r.dec);
         if (!r.stale) exp_q.push_back(core_data_i);
      end
   endtask

   logic [127:0] sd [6];
   logic [127:0] sk [6];
   logic         sdec [6];
   int           n;
   int           nr;
   int           t0;

   initial begin
      reset        = 1'b1;
      load_i       = 1'b0;
      decrypt_i    = 1'b0;
      data_i       = '0;
      key_i        = '0;
      core_valid_i = 1'b0;
      core_data_i  = '0;
      #2;
      chk_zero("rst0");
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Known vector, load held for three cycles.
      n  = iss_q.size();
      nr = rdy_cyc.size();
      data_i    = PT;
      key_i     = KEY;
      decrypt_i = 1'b0;
      load_i    = 1'b1;
      t0        = cyc;
      repeat (3) tick();
      load_i = 1'b0;
      repeat (20) tick();
      chki("t1_issue_count", iss_q.size() - n, 1);
      if (iss_q.size() > n) begin
         chki("t1_issue_cyc", iss_q[n].cyc, t0 + 1);
         chk128("t1_issue_data", iss_q[n].d, PT);
         chk128("t1_issue_key", iss_q[n].k, KEY);
         chk1("t1_issue_dec", iss_q[n].dec, 1'b0);
      end
      chki("t1_ready_count", rdy_cyc.size() - nr, 1);
      if (rdy_cyc.size() > nr) begin
         chki("t1_ready_cyc", rdy_cyc[nr], t0 + 1 + LATENCY + 1);
         chk128("t1_ready_val", rdy_dat[nr], CT);
      end
      chk128("t1_data_hold", data_o, CT);
      chk1("t1_busy_done", busy_o, 1'b0);

      // Stalled core: five starts, then a sixth while the slot is full.
      stall = 1'b1;
      n  = iss_q.size();
      nr = rdy_cyc.size();
      for (int i = 0; i < 5; i++) begin
         sd[i]     = rnd128();
         sk[i]     = rnd128();
         sdec[i]   = 1'($urandom_range(0, 1));
         data_i    = sd[i];
         key_i     = sk[i];
         decrypt_i = sdec[i];
         load_i    = 1'b1;
         tick();
         load_i = 1'b0;
         tick();
         tick();
      end
      chki("t2_issue_count", iss_q.size() - n, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         if (iss_q.size() > n + i) begin
            chk128("t2_issue_data", iss_q[n + i].d, sd[i]);
            chk128("t2_issue_key", iss_q[n + i].k, sk[i]);
         end
      end
      chk1("t2_busy_held", busy_o, 1'b1);
      chk1("t2_no_overflow", overflow_o, 1'b0);
      sd[5]     = rnd128();
      sk[5]     = rnd128();
      data_i    = sd[5];
      key_i     = sk[5];
      decrypt_i = 1'b0;
      load_i    = 1'b1;
      tick();
      load_i = 1'b0;
      repeat (12) tick();
      chk1("t2_overflow", overflow_o, 1'b1);
      chki("t2_issue_still", iss_q.size() - n, DEPTH);
      stall = 1'b0;
      repeat (40) tick();
      chki("t2_ready_count", rdy_cyc.size() - nr, 5);
      if (rdy_cyc.size() >= nr + 5) begin
         for (int i = 0; i < 3; i++)
            chki("t2_ready_gap", rdy_cyc[nr + i + 1] - rdy_cyc[nr + i], GAP + 1);
         for (int i = 0; i < 5; i++)
            chk128("t2_ready_order", rdy_dat[nr + i], core_fn(sd[i], sk[i], sdec[i]));
      end
      if (iss_q.size() > n + DEPTH && rdy_cyc.size() > nr) begin
         chki("t2_fifth_cyc", iss_q[n + DEPTH].cyc, rdy_cyc[nr] + 1);
         chk128("t2_fifth_data", iss_q[n + DEPTH].d, sd[4]);
      end
      chki("t2_total_issues", iss_q.size() - n, 5);
      chk1("t2_busy_done", busy_o, 1'b0);

      // Core strobe with nothing in flight.
      nr = rdy_cyc.size();
      chk1("t3_unexp_before", unexpected_o, 1'b0);
      spur = 1'b1;
      tick();
      tick();
      chk1("t3_unexp_set", unexpected_o, 1'b1);
      repeat (4) tick();
      chki("t3_no_ready", rdy_cyc.size() - nr, 0);

      // Reset mid-flight: the late result must be flagged, not delivered.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk1("t4_flags_clear_ovf", overflow_o, 1'b0);
      chk1("t4_flags_clear_unx", unexpected_o, 1'b0);
      data_i    = rnd128();
      key_i     = rnd128();
      decrypt_i = 1'b1;
      load_i    = 1'b1;
      tick();
      load_i = 1'b0;
      repeat (4) tick();
      chk1("t4_busy_inflight", busy_o, 1'b1);
      nr = rdy_cyc.size();
      reset = 1'b1;
      #1;
      chk_zero("rstmid");
      foreach (core_q[i]) core_q[i].stale = 1'b1;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
      repeat (15) tick();
      chk1("t4_unexp_late", unexpected_o, 1'b1);
      chki("t4_no_ready", rdy_cyc.size() - nr, 0);
      chk1("t4_busy_idle", busy_o, 1'b0);

      // Load already high when reset releases.
      reset = 1'b1;
      tick();
      sd[0]     = rnd128();
      sk[0]     = rnd128();
      sdec[0]   = 1'b0;
      data_i    = sd[0];
      key_i     = sk[0];
      decrypt_i = sdec[0];
      load_i    = 1'b1;
      tick();
      n  = iss_q.size();
      nr = rdy_cyc.size();
      reset = 1'b0;
      t0    = cyc;
      tick();
      tick();
      load_i = 1'b0;
      repeat (15) tick();
      chki("t5_issue_count", iss_q.size() - n, 1);
      if (iss_q.size() > n) begin
         chki("t5_issue_cyc", iss_q[n].cyc, t0 + 1);
         chk128("t5_issue_data", iss_q[n].d, sd[0]);
      end
      chki("t5_ready_count", rdy_cyc.size() - nr, 1);
      if (rdy_cyc.size() > nr)
         chk128("t5_ready_val", rdy_dat[nr], core_fn(sd[0], sk[0], sdec[0]));
      chk1("t5_unexp_clear", unexpected_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
